multi_counter: RTL and testbench

MULTI_COUNTER -- requirements
Module: multi_counter

---
 rtl/multi_counter_pkg.sv | 19 +
 rtl/mc_channel.sv | 107 ++++++++++
 rtl/multi_counter.sv | 55 +++++
 tb/tb_multi_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_pkg.sv
// Package shared by the multi_counter slice.
//   cnt_width(modulus) : bits needed to hold a count in 0..modulus-1
//   step_t             : the kind of update a channel takes on a clock edge
package multi_counter_pkg;

    function automatic int cnt_width(input int modulus);
        return $clog2(modulus);
    endfunction

    // Step kind chosen by a channel each edge, in priority order clr > load > count > hold.
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        UP   = 3'd3,
        DOWN = 3'd4
    } step_t;

endpackage

// File: rtl/mc_channel.sv
// One counter channel: W-bit count register, terminal-count pulse flop and
// sticky limit-event flag.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   ena_n    count enable, active-low
//   dir      1 = count up, 0 = count down
//   clr      synchronous clear (highest priority)
//   load     synchronous load of min(load_val, MODULUS-1)
//   load_val value to load
//   dout     registered count, always < MODULUS
//   tc       one-cycle pulse on the edge that performs a limit step
//   ovf      sticky flag set by a limit step, cleared only by clr or reset
//   step     the step kind being taken on the coming edge (debug visibility)
module mc_channel
    import multi_counter_pkg::*;
#(
    parameter int MODULUS = 128,
    parameter int SAT     = 0,
    parameter int W       = cnt_width(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena_n,
    input  logic         dir,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] dout,
    output logic         tc,
    output logic         ovf,
    output step_t        step
);

    localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);

    logic [W-1:0] dout_nxt;
    logic         tc_nxt;
    logic         ovf_nxt;
    logic         at_limit;

    // Step selection: clr > load > count > hold.
    always_comb begin
        step = HOLD;
        if (clr) begin
            step = CLR;
        end else if (load) begin
            step = LOAD;
        end else if (!ena_n) begin
            step = dir ? UP : DOWN;
        end
    end

    // A limit event is a step taken from the top (up) or from zero (down);
    // it raises tc/ovf in both wrap and saturate modes.
    always_comb begin
        dout_nxt = dout;
        tc_nxt   = 1'b0;
        ovf_nxt  = ovf;
        at_limit = 1'b0;
        case (step)
            CLR: begin
                dout_nxt = '0;
                ovf_nxt  = 1'b0;
            end
            LOAD: begin
                dout_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            end
            UP: begin
                at_limit = (dout == MAX_VAL);
                if (!at_limit) begin
                    dout_nxt = dout + W'(1);
                end else if (SAT == 0) begin
                    dout_nxt = '0;
                end
            end
            DOWN: begin
                at_limit = (dout == '0);
                if (!at_limit) begin
                    dout_nxt = dout - W'(1);
                end else if (SAT == 0) begin
                    dout_nxt = MAX_VAL;
                end
            end
            default: begin
                dout_nxt = dout;
            end
        endcase
        if (at_limit) begin
            tc_nxt  = 1'b1;
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dout <= dout_nxt;
            tc   <= tc_nxt;
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: rtl/multi_counter.sv
// Bank of NCH independent modulo-MODULUS counters.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (release synchronised externally)
//   ena_n     [NCH]    per-channel count enable, active-low
//   dir       [NCH]    per-channel direction, 1 = up
//   clr       [NCH]    per-channel synchronous clear
//   load      [NCH]    per-channel synchronous load
//   load_val  [NCH*W]  per-channel load value, channel i at [i*W +: W]
//   dout      [NCH*W]  per-channel count, channel i at [i*W +: W]
//   tc        [NCH]    per-channel terminal-count pulse
//   ovf       [NCH]    per-channel sticky limit flag
//   step_dbg  [NCH]    per-channel step kind for the coming edge
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MODULUS = 128,
    parameter int SAT     = 0,
    localparam int W      = cnt_width(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ena_n,
    input  logic [NCH-1:0]   dir,
    input  logic [NCH-1:0]   clr,
    input  logic [NCH-1:0]   load,
    input  logic [NCH*W-1:0] load_val,
    output logic [NCH*W-1:0] dout,
    output logic [NCH-1:0]   tc,
    output logic [NCH-1:0]   ovf,
    output step_t            step_dbg [NCH]
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mc_channel #(
            .MODULUS (MODULUS),
            .SAT     (SAT),
            .W       (W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ena_n    (ena_n[i]),
            .dir      (dir[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[i*W +: W]),
            .dout     (dout[i*W +: W]),
            .tc       (tc[i]),
            .ovf      (ovf[i]),
            .step     (step_dbg[i])
        );
    end

endmodule

// File: tb/tb_multi_counter.sv
// Bench for multi_counter: a wrap instance and a saturate instance share the
// same stimulus; a count-level model predicts both every cycle.
module tb_multi_counter;
    import multi_counter_pkg::*;

    localparam int NCH = 4;
    localparam int M   = 10;
    localparam int W   = 4;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   ena_n, dir, clr, load;
    logic [NCH*W-1:0] load_val;
    logic [NCH*W-1:0] dout0, dout1;
    logic [NCH-1:0]   tc0, tc1, ovf0, ovf1;
    step_t            step0 [NCH];
    step_t            step1 [NCH];

    int n_vec = 0;
    int n_err = 0;

    // model state: [sat][channel]
    int m_cnt [2][NCH] = '{default: 0};
    bit m_tc  [2][NCH] = '{default: 0};
    bit m_ovf [2][NCH] = '{default: 0};

    multi_counter #(.NCH(NCH), .MODULUS(M), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .ena_n(ena_n), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .dout(dout0), .tc(tc0), .ovf(ovf0), .step_dbg(step0)
    );

    multi_counter #(.NCH(NCH), .MODULUS(M), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .ena_n(ena_n), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .dout(dout1), .tc(tc1), .ovf(ovf1), .step_dbg(step1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // helpers
    function automatic int ch(input logic [NCH*W-1:0] bus, input int c);
        return int'(bus[c*W +: W]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_lv(input int c, input int v);
        load_val[c*W +: W] = W'(v);
    endtask

    // behavioural model: counts as integers modulo M
    function automatic void model_step(input bit sat, input int c, input int cur,
                                       input bit ovf_cur, output int nxt,
                                       output bit tc_n, output bit ovf_n);
        int lv;
        bit lim;
        nxt   = cur;
        tc_n  = 1'b0;
        ovf_n = ovf_cur;
        if (clr[c]) begin
            nxt   = 0;
            ovf_n = 1'b0;
        end else if (load[c]) begin
            lv  = int'(load_val[c*W +: W]);
            nxt = (lv > M - 1) ? M - 1 : lv;
        end else if (!ena_n[c]) begin
            lim = dir[c] ? (cur == M - 1) : (cur == 0);
            if (lim) begin
                tc_n  = 1'b1;
                ovf_n = 1'b1;
            end
            if (lim && sat) nxt = cur;
            else            nxt = dir[c] ? (cur + 1) % M : (cur + M - 1) % M;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        int  n;
        bit  t, o;
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[s][c] <= 0;
                    m_tc[s][c]  <= 1'b0;
                    m_ovf[s][c] <= 1'b0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < NCH; c++) begin
                    model_step(s[0], c, m_cnt[s][c], m_ovf[s][c], n, t, o);
                    m_cnt[s][c] <= n;
                    m_tc[s][c]  <= t;
                    m_ovf[s][c] <= o;
                end
            end
        end
    end

    // scoreboard compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("wrap dout ch%0d", c), ch(dout0, c), m_cnt[0][c]);
            chk($sformatf("wrap tc ch%0d", c),   int'(tc0[c]),  int'(m_tc[0][c]));
            chk($sformatf("wrap ovf ch%0d", c),  int'(ovf0[c]), int'(m_ovf[0][c]));
            chk($sformatf("sat dout ch%0d", c),  ch(dout1, c), m_cnt[1][c]);
            chk($sformatf("sat tc ch%0d", c),    int'(tc1[c]),  int'(m_tc[1][c]));
            chk($sformatf("sat ovf ch%0d", c),   int'(ovf1[c]), int'(m_ovf[1][c]));
        end
    end

    // directed stimulus with literal expectations
    initial begin
        int n0, n1;
        rst = 1'b0; ena_n = '1; dir = '0; clr = '0; load = '0; load_val = '0;
        tick(2);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset dout ch%0d", c), ch(dout0, c), 0);
            chk($sformatf("reset ovf ch%0d", c), int'(ovf1[c]), 0);
        end
        #2 rst = 1'b1;
        tick(1);

        // ch0 counts up 12 cycles
        ena_n = 4'b1110; dir = 4'b0001; n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n0 += int'(tc0[0]);
            n1 += int'(tc1[0]);
            if (i == 8) chk("up ch0 reaches 9", ch(dout0, 0), 9);
            if (i == 9) chk("up ch0 wraps to 0", ch(dout0, 0), 0);
        end
        chk("up ch0 final", ch(dout0, 0), 2);
        chk("up ch0 tc pulses", n0, 1);
        chk("up ch0 ovf", int'(ovf0[0]), 1);
        for (int c = 1; c < NCH; c++) chk($sformatf("idle ch%0d", c), ch(dout0, c), 0);
        chk("sat up ch0 final", ch(dout1, 0), 9);
        chk("sat up ch0 tc pulses", n1, 3);
        ena_n = '1; dir = '0;

        // ch1 down from 0
        ena_n = 4'b1101; tick(1); ena_n = '1;
        chk("down ch1 wrap", ch(dout0, 1), 9);
        chk("down ch1 tc", int'(tc0[1]), 1);
        chk("sat down ch1 hold", ch(dout1, 1), 0);
        chk("sat down ch1 tc", int'(tc1[1]), 1);
        chk("sat down ch1 ovf", int'(ovf1[1]), 1);
        tick(1);
        chk("down ch1 tc one cycle", int'(tc0[1]), 0);

        // direction change between consecutive steps
        ena_n = 4'b1101; dir = 4'b0010; tick(1);
        chk("dir up ch1", ch(dout0, 1), 0);
        dir = 4'b0000; tick(1);
        chk("dir down ch1", ch(dout0, 1), 9);
        ena_n = '1; dir = '0;

        // ch2 load clamp, ovf kept by load, clr beats load
        load = 4'b0100; set_lv(2, 15); tick(1);
        chk("load clamp ch2", ch(dout0, 2), 9);
        load = '0; ena_n = 4'b1011; dir = 4'b0100; tick(1); ena_n = '1; dir = '0;
        chk("ch2 wrap ovf", int'(ovf0[2]), 1);
        load = 4'b0100; set_lv(2, 15); tick(1);
        chk("load keeps ovf ch2", int'(ovf0[2]), 1);
        clr = 4'b0100; set_lv(2, 4); tick(1); clr = '0; load = '0;
        chk("clr wins dout ch2", ch(dout0, 2), 0);
        chk("clr wins ovf ch2", int'(ovf0[2]), 0);

        // ch3 load beats count at the top
        load = 4'b1000; set_lv(3, 8); tick(1); load = '0;
        ena_n = 4'b0111; dir = 4'b1000; tick(1);
        chk("ch3 up to 9", ch(dout0, 3), 9);
        load = 4'b1000; set_lv(3, 3); tick(1);
        chk("load beats count ch3", ch(dout0, 3), 3);
        chk("load beats count tc ch3", int'(tc0[3]), 0);
        chk("sat load beats count tc ch3", int'(tc1[3]), 0);
        load = '0; ena_n = '1; dir = '0;

        // mixed traffic
        for (int i = 0; i < 300; i++) begin
            ena_n = 4'($urandom_range(0, 15));
            dir   = 4'($urandom_range(0, 15));
            for (int c = 0; c < NCH; c++) begin
                clr[c]  = ($urandom_range(0, 15) == 0);
                load[c] = ($urandom_range(0, 7) == 0);
                set_lv(c, $urandom_range(0, 15));
            end
            tick(1);
        end
        clr = '1; load = '0; ena_n = '1; tick(1); clr = '0;

        // asynchronous reset mid-operation
        load = 4'b0001; set_lv(0, 9); tick(1); load = '0;
        ena_n = 4'b1110; dir = 4'b0001; tick(6);
        chk("pre-reset ch0", ch(dout0, 0), 5);
        chk("pre-reset ovf ch0", int'(ovf0[0]), 1);
        load = 4'b0001; set_lv(0, 7); ena_n = '1;
        #2 rst = 1'b0;
        #1;
        chk("async reset dout ch0", ch(dout0, 0), 0);
        chk("async reset ovf ch0", int'(ovf0[0]), 0);
        chk("async reset sat dout ch0", ch(dout1, 0), 0);
        @(negedge clk);
        load = '0; ena_n = 4'b1110; dir = 4'b0001;
        #2 rst = 1'b1;
        tick(1);
        chk("resume after reset ch0", ch(dout0, 0), 1);
        ena_n = '1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
